// File: rtl/fsm_counter_pkg.sv
// -----------------------------------------------------------------------------
// fsm_counter_pkg
// Shared definitions for the modulo counter family: direction and mode
// encodings, the per-edge action selector, and a binary-to-Gray helper.
// -----------------------------------------------------------------------------
package fsm_counter_pkg;

    // Direction encoding of the 'up' input.
    localparam logic DIR_UP = 1'b1;
    localparam logic DIR_DN = 1'b0;

    // Bound behaviour encoding of the SATURATE parameter.
    localparam int MODE_WRAP = 0;
    localparam int MODE_SAT  = 1;

    // Which control won arbitration on a given edge (clr > load > en > hold).
    typedef enum logic [1:0] {
        ACT_HOLD = 2'd0,
        ACT_CLR  = 2'd1,
        ACT_LOAD = 2'd2,
        ACT_STEP = 2'd3
    } action_e;

    // Binary-to-Gray on a 32-bit carrier; callers truncate to their width.
    // Truncating the result is exact because bit i of the Gray code depends
    // only on bits i and i+1 of the binary value.
    function automatic logic [31:0] bin2gray(input logic [31:0] bin);
        return bin ^ (bin >> 1);
    endfunction

endpackage

// File: rtl/fsm_mod_counter_gray_enc.sv
// -----------------------------------------------------------------------------
// gray_enc
// Combinational WIDTH-bit binary-to-Gray encoder.
// Ports:
//   bin   in  WIDTH  binary value
//   gray  out WIDTH  Gray code of bin
// -----------------------------------------------------------------------------
module gray_enc
    import fsm_counter_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] bin,
    output logic [WIDTH-1:0] gray
);

    logic [31:0] gray_full;

    assign gray_full = bin2gray(32'(bin));
    assign gray      = gray_full[WIDTH-1:0];

endmodule

// File: rtl/fsm_mod_counter.sv
// -----------------------------------------------------------------------------
// fsm_mod_counter
// Modulo-MOD up/down counter whose state register is the count itself.
// Supports synchronous clear, parallel load, and wrap or saturate at bounds.
// All outputs are registered; there is no combinational input-to-output path.
// Ports:
//   clk       in   1      rising-edge clock
//   reset     in   1      asynchronous active-low reset
//   clr       in   1      synchronous clear to 0 (highest priority)
//   load      in   1      synchronous load of load_val
//   load_val  in   WIDTH  value to load; values >= MOD clamp to MOD-1
//   en        in   1      count enable
//   up        in   1      1 = increment, 0 = decrement
//   count     out  WIDTH  binary count
//   gray      out  WIDTH  Gray code of count (same cycle as count)
//   tc        out  1      pulse the cycle after a wrap or bound hit
//   ovf       out  1      sticky overflow: wrap, bound hit or clamped load
//   load_err  out  1      pulse the cycle after an out-of-range load
// -----------------------------------------------------------------------------
module fsm_mod_counter
    import fsm_counter_pkg::*;
#(
    parameter int WIDTH    = 4,
    parameter int MOD      = 10,
    parameter int SATURATE = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    input  logic             up,
    output logic [WIDTH-1:0] count,
    output logic [WIDTH-1:0] gray,
    output logic             tc,
    output logic             ovf,
    output logic             load_err
);

    if (MOD < 2 || MOD > (2 ** WIDTH)) begin : g_bad_mod
        $error("fsm_mod_counter: MOD must satisfy 2 <= MOD <= 2**WIDTH");
    end

    // Comparisons run one bit wider so MOD == 2**WIDTH is representable.
    localparam logic [WIDTH:0]   MOD_W   = (WIDTH + 1)'(MOD);
    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MOD - 1);
    localparam logic             SAT     = (SATURATE == MODE_SAT);

    action_e          action;
    logic [WIDTH-1:0] next_count;
    logic [WIDTH-1:0] next_gray;
    logic             next_tc;
    logic             next_ovf;
    logic             next_load_err;
    logic             load_in_range;
    logic             count_illegal;
    logic             at_top;
    logic             at_bottom;

    assign load_in_range = ({1'b0, load_val} < MOD_W);
    assign count_illegal = ({1'b0, count} >= MOD_W);
    assign at_top        = (count == MAX_VAL);
    assign at_bottom     = (count == '0);

    // -------------------------------------------------------------------------
    // Arbitration: pick the single action that applies this edge.
    // -------------------------------------------------------------------------
    always_comb begin
        action = ACT_HOLD;
        if (clr) begin
            action = ACT_CLR;
        end else if (load) begin
            action = ACT_LOAD;
        end else if (en) begin
            action = ACT_STEP;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state and flag logic.
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every output of this block gets a default before any branch,
        // so no path can leave one unassigned and infer a latch.
        next_count    = count;
        next_tc       = 1'b0;
        next_ovf      = ovf;
        next_load_err = 1'b0;

        unique case (action)
            ACT_CLR: begin
                next_count = '0;
                next_ovf   = 1'b0;
            end

            ACT_LOAD: begin
                if (load_in_range) begin
                    next_count = load_val;
                end else begin
                    next_count    = MAX_VAL;
                    next_load_err = 1'b1;
                    next_ovf      = 1'b1;
                end
            end

            ACT_STEP: begin
                if (count_illegal) begin
                    // Unreachable in normal operation; recover to a known state.
                    next_count = '0;
                end else if (up == DIR_UP) begin
                    if (at_top) begin
                        next_count = SAT ? MAX_VAL : '0;
                        next_tc    = 1'b1;
                        next_ovf   = 1'b1;
                    end else begin
                        next_count = count + WIDTH'(1);
                    end
                end else begin
                    if (at_bottom) begin
                        next_count = SAT ? '0 : MAX_VAL;
                        next_tc    = 1'b1;
                        next_ovf   = 1'b1;
                    end else begin
                        next_count = count - WIDTH'(1);
                    end
                end
            end

            default: begin
                // Hold; an illegal count is still forced back to zero.
                if (count_illegal) begin
                    next_count = '0;
                end
            end
        endcase
    end

    // Gray code is computed from next_count so it lands in the same cycle
    // as the binary count it encodes.
    gray_enc #(
        .WIDTH (WIDTH)
    ) u_gray_enc (
        .bin  (next_count),
        .gray (next_gray)
    );

    // -------------------------------------------------------------------------
    // State register.
    // -------------------------------------------------------------------------
    // NOTE: sequential blocks use non-blocking assignments so every register
    // samples pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else begin
            count <= next_count;
        end
    end

    // -------------------------------------------------------------------------
    // Output registers.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            gray     <= '0;
            tc       <= 1'b0;
            ovf      <= 1'b0;
            load_err <= 1'b0;
        end else begin
            gray     <= next_gray;
            tc       <= next_tc;
            ovf      <= next_ovf;
            load_err <= next_load_err;
        end
    end

endmodule

// File: tb/tb_fsm_mod_counter.sv
// -----------------------------------------------------------------------------
// tb_fsm_mod_counter
// Self-checking bench: a wrap-mode and a saturate-mode instance with
// WIDTH=4 and MOD=10 share the same stimulus. A vector table drives the wrap
// instance; hand-written sequences cover saturation and asynchronous reset.
// -----------------------------------------------------------------------------
module tb_fsm_mod_counter;

    localparam int WIDTH = 4;
    localparam int MOD   = 10;

    logic             clk;
    logic             reset;
    logic             clr;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic             en;
    logic             up;

    logic [WIDTH-1:0] w_count, w_gray, s_count, s_gray;
    logic             w_tc, w_ovf, w_load_err;
    logic             s_tc, s_ovf, s_load_err;

    int total;
    int bad;

    fsm_mod_counter #(.WIDTH(WIDTH), .MOD(MOD), .SATURATE(0)) dut_wrap (
        .clk      (clk),
        .reset    (reset),
        .clr      (clr),
        .load     (load),
        .load_val (load_val),
        .en       (en),
        .up       (up),
        .count    (w_count),
        .gray     (w_gray),
        .tc       (w_tc),
        .ovf      (w_ovf),
        .load_err (w_load_err)
    );

    fsm_mod_counter #(.WIDTH(WIDTH), .MOD(MOD), .SATURATE(1)) dut_sat (
        .clk      (clk),
        .reset    (reset),
        .clr      (clr),
        .load     (load),
        .load_val (load_val),
        .en       (en),
        .up       (up),
        .count    (s_count),
        .gray     (s_gray),
        .tc       (s_tc),
        .ovf      (s_ovf),
        .load_err (s_load_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       clr;
        logic       load;
        logic [3:0] load_val;
        logic       en;
        logic       up;
        logic [3:0] exp_count;
        logic [3:0] exp_gray;
        logic       exp_tc;
        logic       exp_ovf;
        logic       exp_load_err;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Advance one edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic c, input logic l, input logic [3:0] lv,
                         input logic e, input logic u);
        clr      = c;
        load     = l;
        load_val = lv;
        en       = e;
        up       = u;
    endtask

    task automatic check_wrap(input string tag, input logic [3:0] c, input logic [3:0] g,
                              input logic t, input logic o, input logic le);
        check({tag, ".count"},    32'(w_count),    32'(c));
        check({tag, ".gray"},     32'(w_gray),     32'(g));
        check({tag, ".tc"},       32'(w_tc),       32'(t));
        check({tag, ".ovf"},      32'(w_ovf),      32'(o));
        check({tag, ".load_err"}, 32'(w_load_err), 32'(le));
    endtask

    task automatic check_sat(input string tag, input logic [3:0] c, input logic [3:0] g,
                             input logic t, input logic o, input logic le);
        check({tag, ".count"},    32'(s_count),    32'(c));
        check({tag, ".gray"},     32'(s_gray),     32'(g));
        check({tag, ".tc"},       32'(s_tc),       32'(t));
        check({tag, ".ovf"},      32'(s_ovf),      32'(o));
        check({tag, ".load_err"}, 32'(s_load_err), 32'(le));
    endtask

    vec_t vecs[$];

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b0;
        drive(1'b0, 1'b0, 4'd0, 1'b0, 1'b0);

        // Vector table for the wrap instance:
        //          clr   load  lv    en    up     cnt    gray   tc    ovf   lerr
        // Count up 12 cycles from reset: 1..9,0,1,2, tc only when reaching 0.
        vecs.push_back('{1'b0, 1'b0, 4'd0, 1'b1, 1'b1, 4'd1,  4'd1,  1'b0, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 1'b0, 4'd0, 1'b1, 1'b1, 4'd2,  4'd3,  1'b0, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 1'b0, 4'd0, 1'b1, 1'b1, 4'd3,  4'd2,  1'b0, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 1'b0, 4'd0, 1'b1, 1'b1, 4'd4,  4'd6,  1'b0, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 1'b0, 4'd0, 1'b1, 1'b1, 4'd5,  4'd7,  1'b0, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 1'b0, 4'd0, 1'b1, 1'b1, 4'd6,  4'd5,  1'b0, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 1'b0, 4'd0, 1'b1, 1'b1, 4'd7,  4'd4,  1'b0, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 1'b0, 4'd0, 1'b1, 1'b1, 4'd8,  4'd12, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 1'b0, 4'd0, 1'b1, 1'b1, 4'd9,  4'd13, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 1'b0, 4'd0, 1'b1, 1'b1, 4'd0,  4'd0,  1'b1, 1'b1, 1'b0});
        vecs.push_back('{1'b0, 1'b0, 4'd0, 1'b1, 1'b1, 4'd1,  4'd1,  1'b0, 1'b1, 1'b0});
        vecs.push_back('{1'b0, 1'b0, 4'd0, 1'b1, 1'b1, 4'd2,  4'd3,  1'b0, 1'b1, 1'b0});
        // Direction change takes effect immediately; wrap 0 -> 9 pulses tc.
        vecs.push_back('{1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 4'd1,  4'd1,  1'b0, 1'b1, 1'b0});
        vecs.push_back('{1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 4'd0,  4'd0,  1'b0, 1'b1, 1'b0});
        vecs.push_back('{1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 4'd9,  4'd13, 1'b1, 1'b1, 1'b0});
        vecs.push_back('{1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 4'd8,  4'd12, 1'b0, 1'b1, 1'b0});
        // Out-of-range load clamps to 9 and pulses load_err once.
        vecs.push_back('{1'b0, 1'b1, 4'd12, 1'b0, 1'b0, 4'd9, 4'd13, 1'b0, 1'b1, 1'b1});
        vecs.push_back('{1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 4'd9,  4'd13, 1'b0, 1'b1, 1'b0});
        // Load beats enable.
        vecs.push_back('{1'b0, 1'b1, 4'd5, 1'b1, 1'b1, 4'd5,  4'd7,  1'b0, 1'b1, 1'b0});
        // Clear beats load and enable, and clears ovf.
        vecs.push_back('{1'b1, 1'b1, 4'd3, 1'b1, 1'b1, 4'd0,  4'd0,  1'b0, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 1'b0, 4'd0, 1'b1, 1'b1, 4'd1,  4'd1,  1'b0, 1'b0, 1'b0});
        // Loading 0 while enabled down: load wins, no tc.
        vecs.push_back('{1'b0, 1'b1, 4'd0, 1'b1, 1'b0, 4'd0,  4'd0,  1'b0, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 4'd9,  4'd13, 1'b1, 1'b1, 1'b0});
        // Load boundaries: 15 clamps, 9 (MOD-1) is legal.
        vecs.push_back('{1'b0, 1'b1, 4'd15, 1'b0, 1'b0, 4'd9, 4'd13, 1'b0, 1'b1, 1'b1});
        vecs.push_back('{1'b0, 1'b1, 4'd9, 1'b0, 1'b0, 4'd9,  4'd13, 1'b0, 1'b1, 1'b0});
        vecs.push_back('{1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0,  4'd0,  1'b0, 1'b0, 1'b0});

        // Reset state while reset is held low.
        #12;
        check_wrap("reset_wrap", 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
        check_sat("reset_sat", 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);

        @(negedge clk);
        reset = 1'b1;

        foreach (vecs[i]) begin
            drive(vecs[i].clr, vecs[i].load, vecs[i].load_val, vecs[i].en, vecs[i].up);
            tick();
            check_wrap($sformatf("vec%0d", i), vecs[i].exp_count, vecs[i].exp_gray,
                       vecs[i].exp_tc, vecs[i].exp_ovf, vecs[i].exp_load_err);
        end

        // Saturate instance: load 8 then count up, pinned at 9 re-pulses tc.
        drive(1'b1, 1'b0, 4'd0, 1'b0, 1'b0);
        tick();
        drive(1'b0, 1'b1, 4'd8, 1'b0, 1'b0);
        tick();
        check_sat("sat_load8", 4'd8, 4'd12, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 4'd0, 1'b1, 1'b1);
        tick();
        check_sat("sat_up1", 4'd9, 4'd13, 1'b0, 1'b0, 1'b0);
        tick();
        check_sat("sat_up2", 4'd9, 4'd13, 1'b1, 1'b1, 1'b0);
        tick();
        check_sat("sat_up3", 4'd9, 4'd13, 1'b1, 1'b1, 1'b0);
        drive(1'b0, 1'b0, 4'd0, 1'b0, 1'b1);
        tick();
        check_sat("sat_hold", 4'd9, 4'd13, 1'b0, 1'b1, 1'b0);
        // Saturate at the bottom bound.
        drive(1'b1, 1'b0, 4'd0, 1'b0, 1'b0);
        tick();
        drive(1'b0, 1'b0, 4'd0, 1'b1, 1'b0);
        tick();
        check_sat("sat_dn1", 4'd0, 4'd0, 1'b1, 1'b1, 1'b0);
        check_wrap("wrap_dn_shared", 4'd9, 4'd13, 1'b1, 1'b1, 1'b0);
        tick();
        check_sat("sat_dn2", 4'd0, 4'd0, 1'b1, 1'b1, 1'b0);
        // Clamped load on the saturating instance.
        drive(1'b0, 1'b1, 4'd10, 1'b0, 1'b0);
        tick();
        check_sat("sat_load10", 4'd9, 4'd13, 1'b0, 1'b1, 1'b1);

        // Asynchronous reset mid-count at 6.
        drive(1'b1, 1'b0, 4'd0, 1'b0, 1'b0);
        tick();
        drive(1'b0, 1'b0, 4'd0, 1'b1, 1'b1);
        for (int k = 0; k < 6; k++) tick();
        check("pre_reset.count", 32'(w_count), 32'd6);
        #2;
        reset = 1'b0;
        #1;
        check_wrap("async_reset_wrap", 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
        check_sat("async_reset_sat", 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        tick();
        check_wrap("resume", 4'd1, 4'd1, 1'b0, 1'b0, 1'b0);

        // Reset then count down: first edge wraps 0 -> 9 with tc.
        @(negedge clk);
        reset = 1'b0;
        drive(1'b0, 1'b0, 4'd0, 1'b1, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        tick();
        check_wrap("rst_dn1", 4'd9, 4'd13, 1'b1, 1'b1, 1'b0);
        tick();
        check_wrap("rst_dn2", 4'd8, 4'd12, 1'b0, 1'b1, 1'b0);
        tick();
        check_wrap("rst_dn3", 4'd7, 4'd4, 1'b0, 1'b1, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
